// File: rtl/psram_burst_responder.sv
// pSRAM user-command responder: power-up delay, fixed-length bursts, read latency, backed by block RAM.
// Optional macro PSRAM_RESP_STATS_EN adds accepted-command counters wr_cmd_count/rd_cmd_count.
module psram_burst_responder #(
   parameter int MEMORY_BURST    = 32,
   parameter int ADDR_DEPTH_LOG2 = 12,
   parameter int INIT_DELAY      = 100,
   parameter int READ_LATENCY    = 4,
   parameter int WRITE_RECOVERY  = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        init_done,
   input  logic        cmd_en,
   input  logic        cmd,
   input  logic [20:0] addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  data_mask,
   output logic [31:0] rd_data,
   output logic        rd_data_valid,
   output logic        busy,
`ifdef PSRAM_RESP_STATS_EN
   output logic [15:0] wr_cmd_count,
   output logic [15:0] rd_cmd_count,
`endif
   output logic        error
);

   localparam int BW = MEMORY_BURST / 4;
   localparam int IW = $clog2(BW) + 1;
   localparam int AW = ADDR_DEPTH_LOG2;
   localparam int CW = 16;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_RECOVER, S_READ_WAIT, S_READ} state_t;

   state_t          state, state_n;
   logic [AW-1:0]   base, base_n;
   logic [IW-1:0]   idx, idx_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            we, re, acc_wr, acc_rd;
   logic [AW-1:0]   waddr, raddr;
   logic [31:0]     mem [0:(1<<AW)-1];

   logic unused_addr;
   assign unused_addr = ^addr[20:AW];

   assign busy = (state != S_IDLE);

   always_comb begin
      state_n = state;
      base_n  = base;
      idx_n   = idx;
      cnt_n   = cnt;
      we      = 1'b0;
      re      = 1'b0;
      acc_wr  = 1'b0;
      acc_rd  = 1'b0;
      waddr   = base + AW'(idx);
      raddr   = base + AW'(idx);
      case (state)
         S_INIT: begin
            if (cnt == CW'(INIT_DELAY - 1)) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_IDLE: begin
            if (cmd_en) begin
               base_n = addr[AW-1:0];
               if (cmd) begin
                  acc_wr  = 1'b1;
                  we      = 1'b1;
                  waddr   = addr[AW-1:0];
                  idx_n   = IW'(1);
                  state_n = S_WRITE;
               end else begin
                  acc_rd = 1'b1;
                  // With latency 1 the first RAM read has to go out in the command cycle.
                  if (READ_LATENCY == 1) begin
                     re      = 1'b1;
                     raddr   = addr[AW-1:0];
                     idx_n   = IW'(1);
                     state_n = S_READ;
                  end else begin
                     idx_n   = '0;
                     cnt_n   = CW'(1);
                     state_n = S_READ_WAIT;
                  end
               end
            end
         end
         S_WRITE: begin
            we    = 1'b1;
            idx_n = idx + IW'(1);
            if (idx == IW'(BW - 1)) begin
               idx_n   = '0;
               cnt_n   = '0;
               state_n = (WRITE_RECOVERY == 0) ? S_IDLE : S_RECOVER;
            end
         end
         S_RECOVER: begin
            if (cnt == CW'(WRITE_RECOVERY - 1)) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_READ_WAIT: begin
            // cnt holds cycles since the command; issue word 0 one cycle before it is due.
            if (cnt == CW'(READ_LATENCY - 1)) begin
               re      = 1'b1;
               idx_n   = IW'(1);
               cnt_n   = '0;
               state_n = S_READ;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_READ: begin
            // idx counts words already issued; the word on rd_data now is idx-1.
            if (idx == IW'(BW)) begin
               idx_n   = '0;
               state_n = S_IDLE;
            end else begin
               re    = 1'b1;
               idx_n = idx + IW'(1);
            end
         end
         default: state_n = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_INIT;
         base          <= '0;
         idx           <= '0;
         cnt           <= '0;
         init_done     <= 1'b0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
         error         <= 1'b0;
      end else begin
         state         <= state_n;
         base          <= base_n;
         idx           <= idx_n;
         cnt           <= cnt_n;
         rd_data_valid <= re;
         if (state == S_INIT && state_n == S_IDLE) init_done <= 1'b1;
         if (re) rd_data <= mem[raddr];
         if (cmd_en && state != S_IDLE) error <= 1'b1;
      end
   end

   // Backing store is never cleared; a masked byte keeps its old contents.
   always_ff @(posedge clk) begin
      if (we && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (!data_mask[b]) mem[waddr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

`ifdef PSRAM_RESP_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cmd_count <= '0;
         rd_cmd_count <= '0;
      end else begin
         if (acc_wr) wr_cmd_count <= wr_cmd_count + 16'd1;
         if (acc_rd) rd_cmd_count <= rd_cmd_count + 16'd1;
      end
   end
`else
   logic unused_acc;
   assign unused_acc = acc_wr ^ acc_rd;
`endif

endmodule
